// File: rtl/elevator_pkg.sv
// -----------------------------------------------------------------------------
// elevator_pkg
// Shared definitions for the elevator call dispatcher slice.
//   NUM_FLOORS   : number of served floors (one call bit per floor)
//   FLOOR_W      : floor index width
//   DWELL_CYCLES : door-open cycles per stop (>= 1)
//   state_t      : dispatcher FSM states
// -----------------------------------------------------------------------------
package elevator_pkg;

    localparam int NUM_FLOORS   = 4;
    localparam int FLOOR_W      = $clog2(NUM_FLOORS);
    localparam int DWELL_CYCLES = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2,
        S_DOOR = 2'd3
    } state_t;

endpackage

// File: rtl/elevator_call_dispatcher_call_target_select.sv
// -----------------------------------------------------------------------------
// call_target_select
// Combinational view of the pending-call vector relative to the car position.
//   i_pending       : pending call bits, bit i = floor i
//   i_current_floor : car position
//   o_hit           : a call is pending at the current floor
//   o_above         : any call pending above the current floor
//   o_below         : any call pending below the current floor
//   o_next_up       : lowest pending floor above the current floor
//   o_next_down     : highest pending floor below the current floor
// -----------------------------------------------------------------------------
module call_target_select #(
    parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS,
    parameter int FLOOR_W    = elevator_pkg::FLOOR_W
) (
    input  logic [NUM_FLOORS-1:0] i_pending,
    input  logic [FLOOR_W-1:0]    i_current_floor,
    output logic                  o_hit,
    output logic                  o_above,
    output logic                  o_below,
    output logic [FLOOR_W-1:0]    o_next_up,
    output logic [FLOOR_W-1:0]    o_next_down
);

    import elevator_pkg::*;

    assign o_hit = i_pending[i_current_floor];

    // Scanning downward from the top leaves the lowest pending floor above
    // the car in o_next_up; scanning upward from the bottom leaves the
    // highest pending floor below the car in o_next_down.
    always_comb begin
        // NOTE: every output gets a default before the loops so no path leaves
        // it unassigned, otherwise synthesis infers a latch.
        o_above   = 1'b0;
        o_next_up = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (i > int'(i_current_floor) && i_pending[i]) begin
                o_above   = 1'b1;
                o_next_up = FLOOR_W'(i);
            end
        end
    end

    always_comb begin
        o_below     = 1'b0;
        o_next_down = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i < int'(i_current_floor) && i_pending[i]) begin
                o_below     = 1'b1;
                o_next_down = FLOOR_W'(i);
            end
        end
    end

endmodule

// File: rtl/elevator_call_dispatcher.sv
// -----------------------------------------------------------------------------
// elevator_call_dispatcher
// Call-side front end for the elevator controller: latches call buttons,
// schedules service in SCAN order, drives the controller's target floor and
// times the door dwell at each served floor.
//   clk             : clock
//   reset           : asynchronous, active-high reset
//   i_call_btn      : level call buttons, bit i = floor i
//   i_current_floor : car position fed back from the controller
//   o_floor_request : target floor for the controller
//   o_up_request    : step-mode request, unused (tied 0)
//   o_down_request  : step-mode request, unused (tied 0)
//   o_call_led      : pending-call register, one LED per floor
//   o_door_open     : high during the dwell at a served floor
//   o_moving        : travelling and not yet at the requested floor
// -----------------------------------------------------------------------------
module elevator_call_dispatcher #(
    parameter int NUM_FLOORS   = elevator_pkg::NUM_FLOORS,
    parameter int FLOOR_W      = elevator_pkg::FLOOR_W,
    parameter int DWELL_CYCLES = elevator_pkg::DWELL_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] i_call_btn,
    input  logic [FLOOR_W-1:0]    i_current_floor,
    output logic [FLOOR_W-1:0]    o_floor_request,
    output logic                  o_up_request,
    output logic                  o_down_request,
    output logic [NUM_FLOORS-1:0] o_call_led,
    output logic                  o_door_open,
    output logic                  o_moving
);

    import elevator_pkg::*;

    // One extra value of headroom keeps the width non-zero when DWELL_CYCLES is 1.
    localparam int DWELL_W = $clog2(DWELL_CYCLES + 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [NUM_FLOORS-1:0] r_pending;
    logic [NUM_FLOORS-1:0] w_pending_next;
    logic [NUM_FLOORS-1:0] w_call_set;
    logic                  r_dir;          // 0 = up, 1 = down
    logic                  w_dir_next;
    logic [FLOOR_W-1:0]    r_target;
    logic [FLOOR_W-1:0]    w_target_next;
    logic [DWELL_W-1:0]    r_dwell;
    logic [DWELL_W-1:0]    w_dwell_next;
    logic                  w_enter_door;

    logic                  w_hit;
    logic                  w_above;
    logic                  w_below;
    logic [FLOOR_W-1:0]    w_next_up;
    logic [FLOOR_W-1:0]    w_next_down;
    logic [FLOOR_W-1:0]    w_floor_request;

    call_target_select #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_call_target_select (
        .i_pending       (r_pending),
        .i_current_floor (i_current_floor),
        .o_hit           (w_hit),
        .o_above         (w_above),
        .o_below         (w_below),
        .o_next_up       (w_next_up),
        .o_next_down     (w_next_down)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pending <= '0;
            r_dir     <= 1'b0;
            r_target  <= '0;
            r_dwell   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            r_state   <= w_next_state;
            r_pending <= w_pending_next;
            r_dir     <= w_dir_next;
            r_target  <= w_target_next;
            r_dwell   <= w_dwell_next;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        w_next_state  = r_state;
        w_dir_next    = r_dir;
        w_target_next = r_target;
        w_dwell_next  = r_dwell;

        unique case (r_state)
            S_IDLE: begin
                if (w_hit) begin
                    w_next_state = S_DOOR;
                end else if (w_above && w_below) begin
                    // Calls on both sides: keep the last travel direction.
                    w_next_state = r_dir ? S_DOWN : S_UP;
                end else if (w_above) begin
                    w_next_state = S_UP;
                    w_dir_next   = 1'b0;
                end else if (w_below) begin
                    w_next_state = S_DOWN;
                    w_dir_next   = 1'b1;
                end
            end
            S_UP: begin
                if (w_hit) begin
                    w_next_state = S_DOOR;
                end else if (!w_above) begin
                    if (w_below) begin
                        w_next_state = S_DOWN;
                        w_dir_next   = 1'b1;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            S_DOWN: begin
                if (w_hit) begin
                    w_next_state = S_DOOR;
                end else if (!w_below) begin
                    if (w_above) begin
                        w_next_state = S_UP;
                        w_dir_next   = 1'b0;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            S_DOOR: begin
                if (r_dwell == '0) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_dwell_next = r_dwell - DWELL_W'(1);
                end
            end
            default: w_next_state = S_IDLE;
        endcase

        // The target always tracks the nearest call ahead in the travel
        // direction, so a newly latched closer call is picked up en route.
        if (w_next_state == S_UP) begin
            w_target_next = w_next_up;
        end else if (w_next_state == S_DOWN) begin
            w_target_next = w_next_down;
        end

        w_enter_door = (w_next_state == S_DOOR) && (r_state != S_DOOR);
        if (w_enter_door) begin
            w_dwell_next = DWELL_W'(DWELL_CYCLES - 1);
        end

        // A press at the floor being served is dropped, and the service clear
        // wins over a same-edge press at that floor.
        w_call_set = i_call_btn;
        if (r_state == S_DOOR) begin
            w_call_set[i_current_floor] = 1'b0;
        end
        w_pending_next = r_pending | w_call_set;
        if (w_enter_door) begin
            w_pending_next[i_current_floor] = 1'b0;
        end
    end

    // Outputs. The request collapses to the current floor on the arrival cycle
    // (hit) so the controller holds instead of stepping past the stop.
    always_comb begin
        if (r_state == S_DOOR || r_state == S_IDLE || w_hit) begin
            w_floor_request = i_current_floor;
        end else begin
            w_floor_request = r_target;
        end
        o_floor_request = w_floor_request;
        o_door_open     = (r_state == S_DOOR);
        o_moving        = (r_state == S_UP || r_state == S_DOWN) &&
                          (w_floor_request != i_current_floor);
    end

    assign o_call_led     = r_pending;
    assign o_up_request   = 1'b0;
    assign o_down_request = 1'b0;

endmodule

// File: tb/tb_elevator_call_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_elevator_call_dispatcher
// Self-checking bench: a behavioural SCAN model runs in lockstep with the DUT,
// a one-floor-per-clock controller model closes the loop on floor_request,
// and directed scenarios check stop order, dwell length and reset behaviour.
// -----------------------------------------------------------------------------
module tb_elevator_call_dispatcher;

    localparam int NF    = elevator_pkg::NUM_FLOORS;
    localparam int FW    = elevator_pkg::FLOOR_W;
    localparam int DWELL = elevator_pkg::DWELL_CYCLES;

    logic          clk = 1'b0;
    logic          reset;
    logic [NF-1:0] call_btn;
    logic [FW-1:0] cur_floor;
    logic [FW-1:0] o_floor_request;
    logic          o_up_request;
    logic          o_down_request;
    logic [NF-1:0] o_call_led;
    logic          o_door_open;
    logic          o_moving;

    int checks = 0;
    int errors = 0;

    elevator_call_dispatcher dut (
        .clk             (clk),
        .reset           (reset),
        .i_call_btn      (call_btn),
        .i_current_floor (cur_floor),
        .o_floor_request (o_floor_request),
        .o_up_request    (o_up_request),
        .o_down_request  (o_down_request),
        .o_call_led      (o_call_led),
        .o_door_open     (o_door_open),
        .o_moving        (o_moving)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1);
    end

    // Behavioural model of the dispatching rules.
    typedef enum {M_REST, M_ASCEND, M_DESCEND, M_DWELL} mode_e;
    mode_e m_mode;
    bit    m_pend [NF];
    bit    m_down;
    int    m_target;
    int    m_dwell;

    // Observations of the closed-loop run for scenario checks.
    int    obs_stops [$];
    int    obs_floors[$];
    int    obs_door_cycles;
    int    obs_req0_away;
    bit    prev_door;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode   = M_REST;
        m_down   = 1'b0;
        m_target = 0;
        m_dwell  = 0;
        for (int i = 0; i < NF; i++) m_pend[i] = 1'b0;
    endtask

    function automatic logic [NF-1:0] model_led();
        logic [NF-1:0] v;
        for (int i = 0; i < NF; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic int model_fr(input int f);
        if (m_mode == M_DWELL || m_mode == M_REST || m_pend[f]) return f;
        return m_target;
    endfunction

    task automatic model_step(input logic [NF-1:0] btn, input int f);
        bit    hit, above, below;
        int    lo_up, hi_dn;
        bit    newp [NF];
        mode_e nm;
        hit   = m_pend[f];
        above = 1'b0;
        below = 1'b0;
        lo_up = 0;
        hi_dn = 0;
        for (int i = NF - 1; i > f; i--) if (m_pend[i]) begin above = 1'b1; lo_up = i; end
        for (int i = 0; i < f; i++)      if (m_pend[i]) begin below = 1'b1; hi_dn = i; end
        nm = m_mode;
        case (m_mode)
            M_REST: begin
                if (hit)                nm = M_DWELL;
                else if (above && below) nm = m_down ? M_DESCEND : M_ASCEND;
                else if (above) begin   nm = M_ASCEND;  m_down = 1'b0; end
                else if (below) begin   nm = M_DESCEND; m_down = 1'b1; end
            end
            M_ASCEND: begin
                if (hit)                nm = M_DWELL;
                else if (above)         nm = M_ASCEND;
                else if (below) begin   nm = M_DESCEND; m_down = 1'b1; end
                else                    nm = M_REST;
            end
            M_DESCEND: begin
                if (hit)                nm = M_DWELL;
                else if (below)         nm = M_DESCEND;
                else if (above) begin   nm = M_ASCEND;  m_down = 1'b0; end
                else                    nm = M_REST;
            end
            M_DWELL: begin
                if (m_dwell == 0) nm = M_REST;
                else              m_dwell--;
            end
        endcase
        if (nm == M_ASCEND)  m_target = lo_up;
        if (nm == M_DESCEND) m_target = hi_dn;
        newp = m_pend;
        for (int i = 0; i < NF; i++)
            if (btn[i] && !(m_mode == M_DWELL && i == f)) newp[i] = 1'b1;
        if (nm == M_DWELL && m_mode != M_DWELL) begin
            newp[f] = 1'b0;
            m_dwell = DWELL - 1;
        end
        m_mode = nm;
        m_pend = newp;
    endtask

    task automatic check_outputs(input string phase);
        int  f;
        bit  exp_mov;
        f       = int'(cur_floor);
        exp_mov = (m_mode == M_ASCEND || m_mode == M_DESCEND) && (model_fr(f) != f);
        check({phase, ".call_led"},      32'(o_call_led),      32'(model_led()));
        check({phase, ".door_open"},     32'(o_door_open),     32'(m_mode == M_DWELL));
        check({phase, ".floor_request"}, 32'(o_floor_request), 32'(model_fr(f)));
        check({phase, ".moving"},        32'(o_moving),        32'(exp_mov));
        check({phase, ".up_request"},    32'(o_up_request),    32'(0));
        check({phase, ".down_request"},  32'(o_down_request),  32'(0));
    endtask

    // One clock cycle, entered and left at a falling edge. The controller
    // model steps one floor toward the DUT's request after the rising edge.
    task automatic do_cycle(input logic [NF-1:0] btn);
        int f, nf;
        call_btn = btn;
        #1;
        f = int'(cur_floor);
        check_outputs("cyc");
        if (o_door_open === 1'b1 && !prev_door) obs_stops.push_back(f);
        prev_door = (o_door_open === 1'b1);
        if (o_door_open === 1'b1) obs_door_cycles++;
        if (obs_floors.size() == 0 || obs_floors[$] != f) obs_floors.push_back(f);
        if (o_floor_request === '0 && f != 0) obs_req0_away++;
        nf = f;
        if (o_floor_request > cur_floor)      nf = f + 1;
        else if (o_floor_request < cur_floor) nf = f - 1;
        model_step(btn, f);
        @(negedge clk);
        cur_floor = FW'(nf);
    endtask

    task automatic run(input int n);
        repeat (n) do_cycle('0);
    endtask

    task automatic go_to(input int fl);
        do_cycle(NF'(1 << fl));
        run(20);
    endtask

    task automatic clear_obs();
        obs_stops.delete();
        obs_floors.delete();
        obs_door_cycles = 0;
        obs_req0_away   = 0;
    endtask

    // Entered at a falling edge; leaves at a falling edge with reset released.
    task automatic apply_reset(input logic [NF-1:0] btn, input int n);
        reset    = 1'b1;
        call_btn = btn;
        model_reset();
        #1;
        check_outputs("rst");
        repeat (n) begin
            @(negedge clk);
            #1;
            check_outputs("rst");
        end
        @(negedge clk);
        reset    = 1'b0;
        call_btn = '0;
        prev_door = 1'b0;
    endtask

    initial begin
        int exp4 [6];
        logic [NF-1:0] rb;
        exp4 = '{1, 2, 3, 2, 1, 0};
        prev_door = 1'b0;
        clear_obs();
        reset     = 1'b1;
        call_btn  = '1;
        cur_floor = '0;
        model_reset();
        @(negedge clk);

        // 1. Reset with all buttons held.
        apply_reset('1, 2);
        #1;
        check("t1.call_led",      32'(o_call_led),      32'(0));
        check("t1.door_open",     32'(o_door_open),     32'(0));
        check("t1.floor_request", 32'(o_floor_request), 32'(0));
        run(1);

        // 2. Single call to floor 2 from floor 0.
        clear_obs();
        do_cycle(4'b0100);
        #1;
        check("t1.first_press_latched", 32'(o_call_led), 32'(4'b0100));
        run(16);
        check("t2.door_cycles", 32'(obs_door_cycles), 32'(DWELL));
        check("t2.stops",       32'(obs_stops.size()), 32'(1));
        if (obs_stops.size() > 0) check("t2.stop_floor", 32'(obs_stops[0]), 32'(2));
        check("t2.floor_path_len", 32'(obs_floors.size()), 32'(3));
        check("t2.final_floor",    32'(cur_floor),         32'(2));

        // 3. Two calls in the same direction from floor 0.
        go_to(0);
        check("t3.start_floor", 32'(cur_floor), 32'(0));
        clear_obs();
        do_cycle(4'b1010);
        run(30);
        check("t3.stops", 32'(obs_stops.size()), 32'(2));
        if (obs_stops.size() == 2) begin
            check("t3.stop0", 32'(obs_stops[0]), 32'(1));
            check("t3.stop1", 32'(obs_stops[1]), 32'(3));
        end
        check("t3.door_cycles",   32'(obs_door_cycles), 32'(2 * DWELL));
        check("t3.no_request_0",  32'(obs_req0_away),   32'(0));

        // 4. Direction preference: heading to 3, floor 0 called at floor 2.
        go_to(1);
        clear_obs();
        do_cycle(4'b1000);
        for (int k = 0; k < 8 && cur_floor != 2; k++) do_cycle('0);
        check("t4.reached_2", 32'(cur_floor), 32'(2));
        do_cycle(4'b0001);
        run(30);
        check("t4.stops", 32'(obs_stops.size()), 32'(2));
        if (obs_stops.size() == 2) begin
            check("t4.stop0", 32'(obs_stops[0]), 32'(3));
            check("t4.stop1", 32'(obs_stops[1]), 32'(0));
        end
        check("t4.path_len", 32'(obs_floors.size()), 32'(6));
        if (obs_floors.size() == 6)
            for (int i = 0; i < 6; i++) check("t4.path", 32'(obs_floors[i]), 32'(exp4[i]));

        // 5. Call at the current floor while idle, then again during dwell.
        go_to(1);
        clear_obs();
        do_cycle(4'b0010);
        do_cycle('0);
        #1;
        check("t5.door_two_edges", 32'(o_door_open), 32'(1));
        do_cycle(4'b0010);
        #1;
        check("t5.led1_ignored", 32'(o_call_led[1]), 32'(0));
        run(12);
        check("t5.no_motion", 32'(obs_floors.size()), 32'(1));
        check("t5.floor",     32'(cur_floor),         32'(1));
        check("t5.one_stop",  32'(obs_stops.size()),  32'(1));

        // 6. Reset while departing floor 1 toward calls 2 and 3.
        do_cycle(4'b1100);
        do_cycle('0);
        #1;
        check("t6.moving_before_reset", 32'(o_moving), 32'(1));
        apply_reset('0, 1);
        #1;
        check("t6.led_cleared", 32'(o_call_led),      32'(0));
        check("t6.door_closed", 32'(o_door_open),     32'(0));
        check("t6.idle_hold",   32'(o_floor_request), 32'(cur_floor));
        clear_obs();
        run(6);
        check("t6.no_motion", 32'(obs_floors.size()), 32'(1));
        check("t6.floor",     32'(cur_floor),         32'(1));

        // Random call traffic against the model.
        for (int k = 0; k < 400; k++) begin
            int r;
            r  = $urandom_range(0, 7);
            rb = '0;
            if (r == 0)      rb = NF'($urandom_range(0, (1 << NF) - 1));
            else if (r == 1) rb = NF'(1 << $urandom_range(0, NF - 1));
            if (k == 200) apply_reset(NF'($urandom_range(0, (1 << NF) - 1)), 1);
            else          do_cycle(rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
